// File: rtl/vga_timing_gen_if.sv
// Bundle of the run control and all raster outputs of vga_timing_gen.
// The master side is the timing generator. The slave side is the consumer,
// that is, the pixel/colour pipeline and the DAC pin driver.
interface vga_timing_gen_if #(
  parameter int CNT_W   = 11,
  parameter int FRAME_W = 16
);
  logic               enable;
  logic               pix_ce;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic [CNT_W-1:0]   pixel_x;
  logic [CNT_W-1:0]   pixel_y;
  logic               fetch_valid;
  logic [CNT_W-1:0]   fetch_x;
  logic [CNT_W-1:0]   fetch_y;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  enable,
    output pix_ce, hsync, vsync, video_on, pixel_x, pixel_y,
    output fetch_valid, fetch_x, fetch_y, line_start, frame_start, frame_count
  );

  modport slave (
    output enable,
    input  pix_ce, hsync, vsync, video_on, pixel_x, pixel_y,
    input  fetch_valid, fetch_x, fetch_y, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing generator.
// A clock divider produces one pixel tick every CLK_DIV clk cycles. On each tick
// the h/v raster counters advance. The fetch stage is registered from the current
// raster position. A FETCH_LEAD-deep delay line then produces the display-side
// outputs (sync, video_on, x/y), so a memory read issued from fetch_* lines up
// with the display outputs. Sync polarity is applied only at the last register.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int CLK_DIV    = 2,
  parameter int FETCH_LEAD = 2,
  parameter int CNT_W      = 11,
  parameter int FRAME_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // Boundaries are one bit wider than the counters. A zero-porch raster
  // can then put the display width exactly at 2**CNT_W without overflow.
  localparam logic [CNT_W:0] H_DISP_X  = (CNT_W+1)'(H_DISPLAY);
  localparam logic [CNT_W:0] V_DISP_X  = (CNT_W+1)'(V_DISPLAY);
  localparam logic [CNT_W:0] HS_BEG_X  = (CNT_W+1)'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W:0] HS_END_X  = (CNT_W+1)'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0] VS_BEG_X  = (CNT_W+1)'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W:0] VS_END_X  = (CNT_W+1)'(V_DISPLAY + V_FRONT + V_SYNC);

  localparam logic HS_ACT = (HSYNC_POL != 0);
  localparam logic VS_ACT = (VSYNC_POL != 0);

  // Reject parameter sets the counters or the delay line cannot represent.
  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (FETCH_LEAD < 0 || FETCH_LEAD > 15) begin : g_chk_lead
    $error("vga_timing_gen: FETCH_LEAD must be in 0..15");
  end
  if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_chk_cnt
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  // One raster position as it travels from the fetch stage to the display stage.
  // hs/vs are "in sync" flags. They carry no polarity.
  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             vid;
    logic             h0;
    logic             v0;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } stage_t;

  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick;
  logic               pix_ce_q;
  logic [CNT_W-1:0]   h_q, h_d;
  logic [CNT_W-1:0]   v_q, v_d;
  stage_t             cur_s;
  stage_t             disp_in;

  logic               hsync_q;
  logic               vsync_q;
  logic               video_on_q;
  logic [CNT_W-1:0]   pixel_x_q;
  logic [CNT_W-1:0]   pixel_y_q;
  logic               line_start_q;
  logic               frame_start_q;
  logic [FRAME_W-1:0] frame_count_q;

  // Divider next state. tick marks the clk edge where the pixel tick takes effect.
  always_comb begin
    tick  = vga.enable && (div_q == DIV_LAST);
    div_d = div_q;
    if (vga.enable) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
  end

  // Divider state and the registered pix_ce pulse. The pulse drops as soon as enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      pix_ce_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= tick;
    end
  end

  // Raster counter next state: h wraps at the end of a line and carries into v.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Decode the current raster position into the stage record.
  always_comb begin
    cur_s     = '0;
    cur_s.vid = ({1'b0, h_q} < H_DISP_X) && ({1'b0, v_q} < V_DISP_X);
    cur_s.hs  = ({1'b0, h_q} >= HS_BEG_X) && ({1'b0, h_q} < HS_END_X);
    cur_s.vs  = ({1'b0, v_q} >= VS_BEG_X) && ({1'b0, v_q} < VS_END_X);
    cur_s.h0  = (h_q == '0);
    cur_s.v0  = (v_q == '0);
    cur_s.x   = cur_s.vid ? h_q : '0;
    cur_s.y   = cur_s.vid ? v_q : '0;
  end

  if (FETCH_LEAD > 0) begin : g_pipe
    stage_t pipe_q [FETCH_LEAD];

    // Fetch stage (element 0) followed by the look-ahead delay line. It is cleared to idle on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < FETCH_LEAD; i++) begin
          pipe_q[i] <= '0;
        end
      end else if (tick) begin
        pipe_q[0] <= cur_s;
        for (int i = 1; i < FETCH_LEAD; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign disp_in         = pipe_q[FETCH_LEAD-1];
    assign vga.fetch_valid = pipe_q[0].vid;
    assign vga.fetch_x     = pipe_q[0].x;
    assign vga.fetch_y     = pipe_q[0].y;
  end else begin : g_nopipe
    // With no look-ahead the display registers are the fetch stage.
    assign disp_in         = cur_s;
    assign vga.fetch_valid = video_on_q;
    assign vga.fetch_x     = pixel_x_q;
    assign vga.fetch_y     = pixel_y_q;
  end

  // Display stage: applies polarity, produces the line/frame pulses and counts frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (tick) begin
        hsync_q       <= disp_in.hs ? HS_ACT : ~HS_ACT;
        vsync_q       <= disp_in.vs ? VS_ACT : ~VS_ACT;
        video_on_q    <= disp_in.vid;
        pixel_x_q     <= disp_in.x;
        pixel_y_q     <= disp_in.y;
        line_start_q  <= disp_in.h0;
        frame_start_q <= disp_in.h0 && disp_in.v0;
        if (disp_in.h0 && disp_in.v0) begin
          frame_count_q <= frame_count_q + 1'b1;
        end
      end
    end
  end

  assign vga.pix_ce      = pix_ce_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.pixel_x     = pixel_x_q;
  assign vga.pixel_y     = pixel_y_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Three configurations run side by side:
// - the default 640x480 timing with CLK_DIV=2;
// - a tiny 4x3 raster with CLK_DIV=1, active-high syncs and a 2-bit frame counter;
// - a 10x5 raster with CLK_DIV=3 and FETCH_LEAD=0.
// Each configuration gets a random enable pattern and one reset in mid-frame.
// The reference model works from the number of pixel ticks since reset. It
// derives every output from that count with plain modulo arithmetic.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  localparam int N_CFG = 3;
  localparam int HD_A [N_CFG] = '{640, 4, 10};
  localparam int HF_A [N_CFG] = '{16, 1, 2};
  localparam int HS_A [N_CFG] = '{96, 2, 3};
  localparam int HB_A [N_CFG] = '{48, 1, 2};
  localparam int VD_A [N_CFG] = '{480, 3, 5};
  localparam int VF_A [N_CFG] = '{10, 1, 1};
  localparam int VS_A [N_CFG] = '{2, 1, 2};
  localparam int VB_A [N_CFG] = '{33, 1, 1};
  localparam int HP_A [N_CFG] = '{0, 1, 0};
  localparam int VP_A [N_CFG] = '{0, 1, 1};
  localparam int CD_A [N_CFG] = '{2, 1, 3};
  localparam int FL_A [N_CFG] = '{2, 3, 0};
  localparam int FW_A [N_CFG] = '{16, 2, 3};
  localparam int R1_A [N_CFG] = '{4000, 300, 2000};
  localparam int R2_A [N_CFG] = '{2500, 300, 1500};

  genvar gi;
  for (gi = 0; gi < N_CFG; gi++) begin : g_cfg
    localparam int HD = HD_A[gi];
    localparam int HF = HF_A[gi];
    localparam int HS = HS_A[gi];
    localparam int VD = VD_A[gi];
    localparam int VF = VF_A[gi];
    localparam int VS = VS_A[gi];
    localparam int HT = HD + HF + HS + HB_A[gi];
    localparam int VT = VD + VF + VS + VB_A[gi];
    localparam int CD = CD_A[gi];
    localparam int FL = FL_A[gi];
    localparam int FW = FW_A[gi];
    localparam int HP = HP_A[gi];
    localparam int VP = VP_A[gi];

    logic rst_n = 1'b0;
    logic en    = 1'b0;

    vga_timing_gen_if #(.CNT_W(11), .FRAME_W(FW)) bus ();

    vga_timing_gen #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB_A[gi]),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB_A[gi]),
      .HSYNC_POL(HP), .VSYNC_POL(VP), .CLK_DIV(CD), .FETCH_LEAD(FL),
      .CNT_W(11), .FRAME_W(FW)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .vga   (bus)
    );

    assign bus.enable = en;

    // Model state: enabled clk edges and pixel ticks since reset.
    int   ecnt    = 0;
    int   n       = 0;
    logic exp_pce = 1'b0;

    always @(posedge clk) begin
      if (!rst_n) begin
        ecnt    = 0;
        n       = 0;
        exp_pce = 1'b0;
      end else if (en) begin
        ecnt++;
        exp_pce = ((ecnt % CD) == 0);
        if (exp_pce) n++;
      end else begin
        exp_pce = 1'b0;
      end
    end

    // Expected outputs after nn ticks. Fetch shows raster position nn-1.
    // Display shows position nn-1-FL. Negative positions mean the idle reset state.
    int    nn, p, h, v, fh, fv, fval, ex, ey, evid, ehs, evs, els, efs, efc, epce;
    string pre;

    always @(negedge clk) begin
      pre  = $sformatf("c%0d_", gi);
      nn   = rst_n ? n : 0;
      epce = (rst_n && exp_pce) ? 1 : 0;

      fval = 0; fh = 0; fv = 0;
      if (nn >= 1) begin
        p = nn - 1;
        h = p % HT;
        v = (p / HT) % VT;
        if (h < HD && v < VD) begin
          fval = 1; fh = h; fv = v;
        end
      end

      evid = 0; ex = 0; ey = 0; ehs = 1 - HP; evs = 1 - VP; els = 0; efs = 0; efc = 0;
      if (nn - FL >= 1) begin
        p = nn - FL - 1;
        h = p % HT;
        v = (p / HT) % VT;
        if (h < HD && v < VD) begin
          evid = 1; ex = h; ey = v;
        end
        if (h >= HD + HF && h < HD + HF + HS) ehs = HP;
        if (v >= VD + VF && v < VD + VF + VS) evs = VP;
        els = (epce == 1 && h == 0) ? 1 : 0;
        efs = (els == 1 && v == 0) ? 1 : 0;
        efc = ((p / (HT * VT)) + 1) % (1 << FW);
      end

      check_eq({pre, "pix_ce"},      32'(bus.pix_ce),      32'(epce));
      check_eq({pre, "fetch_valid"}, 32'(bus.fetch_valid), 32'(fval));
      check_eq({pre, "fetch_x"},     32'(bus.fetch_x),     32'(fh));
      check_eq({pre, "fetch_y"},     32'(bus.fetch_y),     32'(fv));
      check_eq({pre, "video_on"},    32'(bus.video_on),    32'(evid));
      check_eq({pre, "pixel_x"},     32'(bus.pixel_x),     32'(ex));
      check_eq({pre, "pixel_y"},     32'(bus.pixel_y),     32'(ey));
      check_eq({pre, "hsync"},       32'(bus.hsync),       32'(ehs));
      check_eq({pre, "vsync"},       32'(bus.vsync),       32'(evs));
      check_eq({pre, "line_start"},  32'(bus.line_start),  32'(els));
      check_eq({pre, "frame_start"}, 32'(bus.frame_start), 32'(efs));
      check_eq({pre, "frame_count"}, 32'(bus.frame_count), 32'(efc));
    end

    // Stimulus: two run phases with random enable gaps, a fixed 37-clk gap
    // in each phase, and an asynchronous reset in mid-frame between them.
    initial begin
      int off_left;
      int run_len;
      off_left = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      en = 1'b1;
      for (int ph = 0; ph < 2; ph++) begin
        run_len = (ph == 0) ? R1_A[gi] : R2_A[gi];
        for (int i = 0; i < run_len; i++) begin
          @(posedge clk);
          #2;
          if (i == run_len / 3) begin
            en = 1'b0;
            off_left = 36;
          end else if (!en) begin
            if (off_left == 0) en = 1'b1;
            else off_left--;
          end else if ($urandom_range(0, 249) == 0) begin
            en = 1'b0;
            off_left = int'($urandom_range(0, 39));
          end
        end
        if (ph == 0) begin
          @(posedge clk);
          #2 rst_n = 1'b0;
          repeat (2) @(posedge clk);
          #2 rst_n = 1'b1;
          en = 1'b1;
        end
      end
      $display("cfg %0d done: %0d ticks in final run", gi, n);
      done_cnt++;
    end
  end

  initial begin
    wait (done_cnt == N_CFG);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. It is the next generation of the fixed 640x480 controller. It adds programmable timing, sync polarity, and an internal pixel-clock divider, so the block runs off the 50 MHz system clock. It also provides a look-ahead fetch port, so framebuffer/ROM reads with FETCH_LEAD cycles of latency line up with the delayed sync and video_on outputs. It sits between the system clock domain and the VGA DAC pins; the pixel/colour pipeline consumes its fetch and display outputs.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
CLK_DIV, 2, clk cycles per pixel tick (>=1; 1 = clk is the pixel clock)
FETCH_LEAD, 2, pixel ticks by which fetch_* precede display outputs (0..15)
CNT_W, 11, width of the h/v counters and coordinate outputs
FRAME_W, 16, frame counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run; when low, the divider and counters freeze and all outputs hold
pix_ce  out  1  one-clk pulse per pixel tick
hsync  out  1  horizontal sync, polarity HSYNC_POL
vsync  out  1  vertical sync, polarity VSYNC_POL
video_on  out  1  display pixel valid
pixel_x  out  CNT_W  display x; 0 when video_on=0
pixel_y  out  CNT_W  display y; 0 when video_on=0
fetch_valid  out  1  fetch coordinate is in the visible area
fetch_x  out  CNT_W  x of the pixel to request now; 0 when not valid
fetch_y  out  CNT_W  y of the pixel to request now; 0 when not valid
line_start  out  1  one-clk pulse coincident with pix_ce when display h position = 0
frame_start  out  1  one-clk pulse coincident with pix_ce when display h=0 and v=0
frame_count  out  FRAME_W  frames completed, wraps modulo 2^FRAME_W

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Line order: display, front porch, sync, back porch.
- hsync is active for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC). vsync uses the same rule on v.
- Divider: the counter runs 0..CLK_DIV-1 while enable=1. pix_ce=1 in the clk cycle where the divider equals CLK_DIV-1. With CLK_DIV=1, pix_ce = enable.
- Raster counters h, v advance only on pix_ce:
  - h wraps at H_TOTAL-1.
  - v increments when h wraps, and wraps at V_TOTAL-1.
- Fetch stage: registered on pix_ce from the current (h,v).
  - fetch_valid = (h<H_DISPLAY && v<V_DISPLAY).
  - fetch_x/fetch_y = h/v when valid, else 0.
- Display stage: {sync, video_on, x, y} pass through a FETCH_LEAD-deep shift register clocked by pix_ce.
  - Display outputs at tick t equal fetch-stage values from tick t-FETCH_LEAD.
  - FETCH_LEAD=0 makes display equal fetch (same register).
- Sync polarity: hsync/vsync are driven at the active level only during sync. Polarity is applied at the final register, so there are no glitches.
- line_start/frame_start derive from the display stage, not the fetch stage. frame_start asserts together with line_start.
- frame_count increments by 1 in the same clk as each frame_start (first frame_start after reset gives 1).
- Reset: all counters 0 and every delay-line stage is cleared to the inactive state. After reset:
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - video_on, fetch_valid, pix_ce, line_start, frame_start = 0.
  - All coordinates 0, frame_count = 0.
- First tick after reset: the first pix_ce occurs CLK_DIV clk cycles after rst_n deasserts with enable=1. The fetch stage shows (0,0) valid after that tick. The display stage shows (0,0) FETCH_LEAD ticks later.
- Reset mid-frame: asynchronous clear on the same edge; there is no partial-frame continuation.
- enable low: the divider does not advance, no pix_ce, and all outputs hold their last values. Pulse outputs deassert on the next clk.
- Elaboration check: CNT_W must hold H_TOTAL-1 and V_TOTAL-1. Default totals are 800 and 525.

Test Plan:
- Defaults, CLK_DIV=2: count pix_ce per line and frame -> 800 ticks between line_starts, 420000 ticks between frame_starts. hsync low for exactly 96 ticks starting 656 ticks after line_start. vsync low 2 lines starting at line 490.
- Fetch alignment, FETCH_LEAD=2: log fetch (x,y) and display (x,y) per tick -> display equals fetch delayed by exactly 2 ticks. fetch_valid rises at tick 1 after reset and video_on at tick 3. Display x steps 0..639 then 0 with video_on=0.
- Small raster: H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, HSYNC_POL=VSYNC_POL=1 -> 8-tick lines, 48-tick frames. hsync high at h=5,6 and vsync high on line 4. frame_count reads 1, 2, 3 after 3 frames.
- Frame counter wrap: FRAME_W=2, small raster -> frame_count sequence 1, 2, 3, 0, 1.
- enable: deassert for 37 clk mid-line -> no pix_ce, all outputs frozen. Reassert -> raster resumes at the next position, and the line period measured in ticks is unchanged.
- Reset mid-frame at v=200, h=300 -> same-edge outputs hsync=~HSYNC_POL, video_on=0, frame_count=0. Raster restarts at (0,0) as in the first-tick rule.
